ping_pong_bank_ctrl: RTL and testbench

//  Sequencer for a two-bank (ping/pong) buffer between a producer (linear projection outputs Q/K) and the Qn*KnT core.

---
 rtl/ping_pong_bank_ctrl_pkg.sv | 27 ++
 rtl/ping_pong_bank_ctrl_if.sv | 31 +++
 rtl/ping_pong_bank_ctrl_rd_latency_pipe.sv | 43 ++++
 rtl/ping_pong_bank_ctrl.sv | 129 ++++++++++++
 tb/tb_ping_pong_bank_ctrl.sv | 383 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ping_pong_bank_ctrl_pkg.sv
// Shared types and instance sizing for the ping/pong bank sequencers.
package ping_pong_pkg;

  typedef enum logic [1:0] {
    PP_EMPTY,
    PP_FILLING,
    PP_FULL,
    PP_DRAINING
  } pp_bank_state_t;

  // West and north buffer sizing; instances pick one pair.
  localparam int unsigned W_TOTAL_DEPTH = 8;
  localparam int unsigned ADDR_WIDTH_W  = 3;
  localparam int unsigned N_TOTAL_DEPTH = 8;
  localparam int unsigned ADDR_WIDTH_N  = 3;

  // A bank may take producer words until it has been completely written.
  function automatic logic pp_writable(input pp_bank_state_t s);
    return (s == PP_EMPTY) || (s == PP_FILLING);
  endfunction

  // A bank holds unread data once fully written and until its last pass ends.
  function automatic logic pp_readable(input pp_bank_state_t s);
    return (s == PP_FULL) || (s == PP_DRAINING);
  endfunction

endpackage

// File: rtl/ping_pong_bank_ctrl_if.sv
// Producer/consumer/RAM-side signal bundle of the ping/pong bank controller.
interface ping_pong_bank_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 3
);
  logic                  clear;
  logic                  in_valid;
  logic                  in_ready;
  logic                  wr_en;
  logic                  wr_bank;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic                  rd_req;
  logic                  rd_en;
  logic                  rd_bank;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_valid;
  logic                  rd_last;
  logic                  pass_done;
  logic [1:0]            bank_full;

  modport master (
    output clear, in_valid, rd_req,
    input  in_ready, wr_en, wr_bank, wr_addr, rd_en, rd_bank, rd_addr,
    input  rd_valid, rd_last, pass_done, bank_full
  );

  modport slave (
    input  clear, in_valid, rd_req,
    output in_ready, wr_en, wr_bank, wr_addr, rd_en, rd_bank, rd_addr,
    output rd_valid, rd_last, pass_done, bank_full
  );
endinterface

// File: rtl/ping_pong_bank_ctrl_rd_latency_pipe.sv
// Delays the read strobe and its last-word flag to line up with RAM data.
module pp_rd_latency_pipe #(
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic in_valid,
  input  logic in_last,
  output logic out_valid,
  output logic out_last
);

  logic [RD_LATENCY-1:0] valid_q, valid_d;
  logic [RD_LATENCY-1:0] last_q, last_d;

  // Shift one stage per cycle; last is only meaningful alongside valid.
  always_comb begin
    valid_d    = valid_q;
    last_d     = last_q;
    valid_d[0] = in_valid;
    last_d[0]  = in_valid & in_last;
    for (int i = 1; i < RD_LATENCY; i++) begin
      valid_d[i] = valid_q[i-1];
      last_d[i]  = last_q[i-1];
    end
  end

  // Pipe registers, flushed by reset or clear.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      valid_q <= '0;
      last_q  <= '0;
    end else begin
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign out_valid = valid_q[RD_LATENCY-1];
  assign out_last  = last_q[RD_LATENCY-1];

endmodule

// File: rtl/ping_pong_bank_ctrl.sv
// Ping/pong bank sequencer: write and read address streams plus per-bank ownership.
module ping_pong_bank_ctrl
  import ping_pong_pkg::*;
#(
  parameter int unsigned DEPTH      = W_TOTAL_DEPTH,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_W,
  parameter int unsigned NUM_PASSES = 1,
  parameter int unsigned RD_LATENCY = 1
) (
  input logic                  clk,
  input logic                  rst_n,
  ping_pong_bank_ctrl_if.slave bus
);

  localparam int unsigned PassW = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;
  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [PassW-1:0]      LastPass = PassW'(NUM_PASSES - 1);

  pp_bank_state_t        bank_q [2];
  pp_bank_state_t        bank_d [2];
  logic                  wr_bank_q, wr_bank_d;
  logic                  rd_bank_q, rd_bank_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [PassW-1:0]      pass_q, pass_d;

  logic in_ready;
  logic wr_en;
  logic rd_en;
  logic rd_word_last;
  logic rd_final;
  logic pipe_valid;
  logic pipe_last;

  // State register; clear behaves exactly like reset and overrides all other events.
  always_ff @(posedge clk) begin
    if (!rst_n || bus.clear) begin
      bank_q[0] <= PP_EMPTY;
      bank_q[1] <= PP_EMPTY;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_addr_q <= '0;
      rd_addr_q <= '0;
      pass_q    <= '0;
    end else begin
      bank_q[0] <= bank_d[0];
      bank_q[1] <= bank_d[1];
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_addr_q <= wr_addr_d;
      rd_addr_q <= rd_addr_d;
      pass_q    <= pass_d;
    end
  end

  // Next state: writer updates its bank first, reader second so a release wins a collision.
  always_comb begin
    bank_d[0] = bank_q[0];
    bank_d[1] = bank_q[1];
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_addr_d = wr_addr_q;
    rd_addr_d = rd_addr_q;
    pass_d    = pass_q;

    if (wr_en) begin
      if (wr_addr_q == LastAddr) begin
        bank_d[wr_bank_q] = PP_FULL;
        wr_addr_d         = '0;
        wr_bank_d         = ~wr_bank_q;
      end else begin
        bank_d[wr_bank_q] = PP_FILLING;
        wr_addr_d         = wr_addr_q + 1'b1;
      end
    end

    if (rd_en) begin
      if (bank_q[rd_bank_q] == PP_FULL) begin
        bank_d[rd_bank_q] = PP_DRAINING;
      end
      if (rd_word_last) begin
        rd_addr_d = '0;
        if (rd_final) begin
          bank_d[rd_bank_q] = PP_EMPTY;
          pass_d            = '0;
          rd_bank_d         = ~rd_bank_q;
        end else begin
          pass_d = pass_q + 1'b1;
        end
      end else begin
        rd_addr_d = rd_addr_q + 1'b1;
      end
    end
  end

  // Outputs: handshake and strobes decoded from the registered bank states.
  always_comb begin
    in_ready     = pp_writable(bank_q[wr_bank_q]);
    wr_en        = bus.in_valid & in_ready;
    rd_en        = bus.rd_req & pp_readable(bank_q[rd_bank_q]);
    rd_word_last = rd_en & (rd_addr_q == LastAddr);
    rd_final     = rd_word_last & (pass_q == LastPass);
  end

  pp_rd_latency_pipe #(
    .RD_LATENCY(RD_LATENCY)
  ) u_rd_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (bus.clear),
    .in_valid (rd_en),
    .in_last  (rd_word_last),
    .out_valid(pipe_valid),
    .out_last (pipe_last)
  );

  assign bus.in_ready  = in_ready;
  assign bus.wr_en     = wr_en;
  assign bus.wr_bank   = wr_bank_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.rd_en     = rd_en;
  assign bus.rd_bank   = rd_bank_q;
  assign bus.rd_addr   = rd_addr_q;
  assign bus.rd_valid  = pipe_valid;
  assign bus.rd_last   = pipe_last;
  assign bus.pass_done = pipe_last;
  assign bus.bank_full = {pp_readable(bank_q[1]), pp_readable(bank_q[0])};

endmodule

// File: tb/tb_ping_pong_bank_ctrl.sv
// Bench: two controllers (1 pass / latency 1 and 3 passes / latency 3, both DEPTH 4)
// share one stimulus stream and are compared against a word-counting reference model.
module tb_ping_pong_bank_ctrl;

  localparam int Depth = 4;
  localparam int Aw    = 2;

  logic clk      = 1'b0;
  logic rst_n    = 1'b0;
  logic clear    = 1'b0;
  logic in_valid = 1'b0;
  logic rd_req   = 1'b0;

  always #5 clk = ~clk;

  ping_pong_bank_ctrl_if #(.ADDR_WIDTH(Aw)) bus0 ();
  ping_pong_bank_ctrl_if #(.ADDR_WIDTH(Aw)) bus1 ();

  assign bus0.clear    = clear;
  assign bus0.in_valid = in_valid;
  assign bus0.rd_req   = rd_req;
  assign bus1.clear    = clear;
  assign bus1.in_valid = in_valid;
  assign bus1.rd_req   = rd_req;

  ping_pong_bank_ctrl #(
    .DEPTH(Depth), .ADDR_WIDTH(Aw), .NUM_PASSES(1), .RD_LATENCY(1)
  ) dut0 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus0)
  );

  ping_pong_bank_ctrl #(
    .DEPTH(Depth), .ADDR_WIDTH(Aw), .NUM_PASSES(3), .RD_LATENCY(3)
  ) dut1 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus1)
  );

  // Reference model: words written into each bank, words read out of it (all passes),
  // and a calendar of cycles on which read data / last flags are due.
  int cyc = 0;
  int m_words [2][2];
  int m_reads [2][2];
  int m_wb [2];
  int m_rb [2];
  bit sv [2][64];
  bit sl [2][64];

  // Observed / expected vector layout:
  // {in_ready, wr_en, wr_bank, wr_addr[1:0], rd_en, rd_bank, rd_addr[1:0],
  //  rd_valid, rd_last, pass_done, bank_full[1:0]}
  logic [13:0] obs [2];
  logic [13:0] exp_v [2];

  int compared   = 0;
  int mismatched = 0;

  function automatic int np(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic int rl(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_wb[k] = 0;
      m_rb[k] = 0;
      for (int b = 0; b < 2; b++) begin
        m_words[k][b] = 0;
        m_reads[k][b] = 0;
      end
      for (int i = 0; i < 64; i++) begin
        sv[k][i] = 1'b0;
        sl[k][i] = 1'b0;
      end
    end
  endfunction

  function automatic void model_step();
    if (!rst_n || clear) begin
      model_reset();
    end else begin
      for (int k = 0; k < 2; k++) begin
        int  wb;
        int  rb;
        bit  we;
        bit  re;
        wb = m_wb[k];
        rb = m_rb[k];
        we = in_valid && (m_words[k][wb] < Depth);
        re = rd_req && (m_words[k][rb] == Depth);
        sv[k][cyc % 64] = 1'b0;
        sl[k][cyc % 64] = 1'b0;
        if (we) begin
          m_words[k][wb]++;
          if (m_words[k][wb] == Depth) m_wb[k] = 1 - wb;
        end
        if (re) begin
          m_reads[k][rb]++;
          sv[k][(cyc + rl(k)) % 64] = 1'b1;
          sl[k][(cyc + rl(k)) % 64] = (m_reads[k][rb] % Depth) == 0;
          if (m_reads[k][rb] == Depth * np(k)) begin
            m_words[k][rb] = 0;
            m_reads[k][rb] = 0;
            m_rb[k]        = 1 - rb;
          end
        end
      end
    end
    cyc++;
  endfunction

  function automatic void sample();
    obs[0] = {bus0.in_ready, bus0.wr_en, bus0.wr_bank, bus0.wr_addr, bus0.rd_en, bus0.rd_bank,
              bus0.rd_addr, bus0.rd_valid, bus0.rd_last, bus0.pass_done, bus0.bank_full};
    obs[1] = {bus1.in_ready, bus1.wr_en, bus1.wr_bank, bus1.wr_addr, bus1.rd_en, bus1.rd_bank,
              bus1.rd_addr, bus1.rd_valid, bus1.rd_last, bus1.pass_done, bus1.bank_full};
    for (int k = 0; k < 2; k++) begin
      int         wb;
      int         rb;
      int         s;
      bit         ir;
      bit         re;
      logic [1:0] wa;
      logic [1:0] ra;
      logic [1:0] bf;
      wb = m_wb[k];
      rb = m_rb[k];
      s  = cyc % 64;
      ir = m_words[k][wb] < Depth;
      re = rd_req && (m_words[k][rb] == Depth);
      wa = 2'(m_words[k][wb] % Depth);
      ra = 2'(m_reads[k][rb] % Depth);
      bf = {m_words[k][1] == Depth, m_words[k][0] == Depth};
      exp_v[k] = {ir, in_valid && ir, 1'(wb), wa, re, 1'(rb), ra, sv[k][s], sl[k][s], sl[k][s], bf};
    end
  endfunction

  task automatic drive(input logic iv, input logic rr, input logic cl);
    in_valid = iv;
    rd_req   = rr;
    clear    = cl;
    @(negedge clk);
    sample();
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) begin
      drive(1'b0, 1'b0, 1'b0);
      tick();
    end
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      compared++;
      if (obs[k] !== 14'h2000) begin
        mismatched++;
        $display("FAIL reset_state dut%0d: got %h expected %h", k, obs[k], 14'h2000);
      end
      compared++;
      if (obs[k] !== exp_v[k]) begin
        mismatched++;
        $display("FAIL reset_model dut%0d: got %h expected %h", k, obs[k], exp_v[k]);
      end
    end
    tick();
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 22; i++) begin
      if (i == 0)     drive(1'b0, 1'b0, 1'b1);
      else if (i < 5) drive(1'b1, 1'b0, 1'b0);
      else            drive(1'b0, (i > 5), 1'b0);
      for (int k = 0; k < 2; k++) begin
        compared++;
        if (obs[k] !== exp_v[k]) begin
          mismatched++;
          $display("FAIL fill_drain dut%0d cyc %0d: got %h expected %h", k, cyc, obs[k], exp_v[k]);
        end
        if (i == 5) begin
          compared++;
          if (obs[k][1:0] !== 2'b01) begin
            mismatched++;
            $display("FAIL fill_drain_full dut%0d: got %b expected 01", k, obs[k][1:0]);
          end
        end
        if (i == 21) begin
          compared++;
          if (obs[k][1:0] !== 2'b00) begin
            mismatched++;
            $display("FAIL fill_drain_released dut%0d: got %b expected 00", k, obs[k][1:0]);
          end
        end
      end
      tick();
    end
  endtask

  task automatic test_fill_both();
    for (int i = 0; i < 14; i++) begin
      drive(i != 0, 1'b0, i == 0);
      for (int k = 0; k < 2; k++) begin
        compared++;
        if (obs[k] !== exp_v[k]) begin
          mismatched++;
          $display("FAIL fill_both dut%0d cyc %0d: got %h expected %h", k, cyc, obs[k], exp_v[k]);
        end
        if (i == 13) begin
          compared++;
          if ({obs[k][13], obs[k][11], obs[k][1:0]} !== 4'b0011) begin
            mismatched++;
            $display("FAIL fill_both_stall dut%0d: got ready/bank/full %b expected 0011",
                     k, {obs[k][13], obs[k][11], obs[k][1:0]});
          end
        end
      end
      tick();
    end
  endtask

  // Runs straight after test_fill_both: both banks hold unread data.
  task automatic test_multi_pass();
    int n_rd;
    int n_pd;
    n_rd = 0;
    n_pd = 0;
    for (int i = 0; i < 17; i++) begin
      logic [1:0] ea;
      ea = 2'(i % 4);
      drive(1'b0, i < 12, 1'b0);
      for (int k = 0; k < 2; k++) begin
        compared++;
        if (obs[k] !== exp_v[k]) begin
          mismatched++;
          $display("FAIL multi_pass dut%0d cyc %0d: got %h expected %h", k, cyc, obs[k], exp_v[k]);
        end
      end
      if (i < 12) begin
        compared++;
        if ({obs[1][7], obs[1][6:5]} !== {1'b0, ea}) begin
          mismatched++;
          $display("FAIL multi_pass_addr step %0d: got bank/addr %b expected %b",
                   i, {obs[1][7], obs[1][6:5]}, {1'b0, ea});
        end
      end
      n_rd += int'(obs[1][8] === 1'b1);
      n_pd += int'(obs[1][2] === 1'b1);
      if (i == 16) begin
        compared++;
        if ({n_rd, n_pd} !== {32'd12, 32'd3} || obs[1][1:0] !== 2'b10) begin
          mismatched++;
          $display("FAIL multi_pass_count: got rd_en %0d pass_done %0d full %b expected 12 3 10",
                   n_rd, n_pd, obs[1][1:0]);
        end
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    int stalls;
    stalls = 0;
    for (int i = 0; i < 41; i++) begin
      drive(i != 0, i != 0, i == 0);
      for (int k = 0; k < 2; k++) begin
        compared++;
        if (obs[k] !== exp_v[k]) begin
          mismatched++;
          $display("FAIL back_to_back dut%0d cyc %0d: got %h expected %h", k, cyc, obs[k], exp_v[k]);
        end
      end
      if (i > 0) stalls += int'(obs[0][13] !== 1'b1);
      tick();
    end
    compared++;
    if (stalls != 0) begin
      mismatched++;
      $display("FAIL back_to_back_ready: got %0d stall cycles expected 0", stalls);
    end
  endtask

  task automatic test_clear();
    for (int i = 0; i < 10; i++) begin
      if (i == 0)      drive(1'b0, 1'b0, 1'b1);
      else if (i < 7)  drive(1'b1, 1'b0, 1'b0);
      else if (i == 7) drive(1'b0, 1'b1, 1'b0);
      else if (i == 8) drive(1'b0, 1'b1, 1'b1);
      else             drive(1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 2; k++) begin
        compared++;
        if (obs[k] !== exp_v[k]) begin
          mismatched++;
          $display("FAIL clear dut%0d cyc %0d: got %h expected %h", k, cyc, obs[k], exp_v[k]);
        end
        if (i == 9) begin
          compared++;
          if (obs[k] !== 14'h2000) begin
            mismatched++;
            $display("FAIL clear_flush dut%0d: got %h expected %h", k, obs[k], 14'h2000);
          end
        end
      end
      tick();
    end
  endtask

  task automatic test_latency();
    int q [$];
    int words;
    words = 0;
    for (int i = 0; i < 34; i++) begin
      if (i == 0)     drive(1'b0, 1'b0, 1'b1);
      else if (i < 5) drive(1'b1, 1'b0, 1'b0);
      else            drive(1'b0, (i < 29) && (i % 2 == 1), 1'b0);
      for (int k = 0; k < 2; k++) begin
        compared++;
        if (obs[k] !== exp_v[k]) begin
          mismatched++;
          $display("FAIL latency dut%0d cyc %0d: got %h expected %h", k, cyc, obs[k], exp_v[k]);
        end
      end
      if (i > 0 && obs[1][4] === 1'b1) begin
        int issued;
        issued = (q.size() > 0) ? q.pop_front() : -100;
        compared++;
        if (cyc - issued != 3 || obs[1][3] !== ((words % 4) == 3)) begin
          mismatched++;
          $display("FAIL latency_align word %0d: got delay %0d last %b expected 3 %b",
                   words, cyc - issued, obs[1][3], (words % 4) == 3);
        end
        words++;
      end
      if (i > 0 && obs[1][8] === 1'b1) q.push_back(cyc);
      tick();
    end
    compared++;
    if (words != 12) begin
      mismatched++;
      $display("FAIL latency_words: got %0d expected 12", words);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 63) == 0);
      for (int k = 0; k < 2; k++) begin
        compared++;
        if (obs[k] !== exp_v[k]) begin
          mismatched++;
          $display("FAIL random dut%0d cyc %0d: got %h expected %h", k, cyc, obs[k], exp_v[k]);
        end
      end
      tick();
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_fill_drain();
    test_fill_both();
    test_multi_pass();
    test_back_to_back();
    test_clear();
    test_latency();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
